// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   Consumer end of the sign-magnitude multiplier output bus for one neuron
//   MAC lane. Wide (2*BIT-1) sign-magnitude products are summed in a
//   saturating two's-complement accumulator. The closed sum is then rounded
//   half away from zero, rescaled from 2*FRAC to FRAC fractional bits and
//   saturated back to a BIT-wide sign-magnitude word.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   iClear  in   synchronous abort: drop partial sum, return to IDLE
//   iValid  in   iProd/iLast valid
//   oReady  out  block accepts a beat this cycle (IDLE or ACC)
//   iProd   in   [2*BIT-2] sign, [2*BIT-3:0] magnitude
//   iLast   in   accepted beat closes the sum
//   oValid  out  oNum valid
//   iReady  in   downstream takes oNum
//   oNum    out  [BIT-1] sign, [BIT-2:0] magnitude
//   oSat    out  result or accumulator clipped (qualified by oValid)
//   oCount  out  beats in current/last sum
//   oState  out  FSM state for debug: 0 IDLE, 1 ACC, 2 ROUND, 3 HOLD
//
// Configuration:
//   RELU_EN  when defined, a negative sum produces oNum = 0 in ROUND; that
//            clip does not raise oSat (positive saturation still does).
//
// Handshake: a beat transfers on a rising edge where iValid & oReady are both
// high; a result transfers on a rising edge where oValid & iReady are both
// high. oNum/oSat stay stable while oValid is high and iReady is low.
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int BIT       = 16,
  parameter int FRAC      = 10,
  parameter int ACC_W     = 36,
  parameter int MAX_TERMS = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           iClear,
  input  logic                           iValid,
  output logic                           oReady,
  input  logic [2*BIT-2:0]               iProd,
  input  logic                           iLast,
  output logic                           oValid,
  input  logic                           iReady,
  output logic [BIT-1:0]                 oNum,
  output logic                           oSat,
  output logic [$clog2(MAX_TERMS+1)-1:0] oCount,
  output logic [1:0]                     oState
);

  localparam int MW = 2*BIT-2;                 // product magnitude width
  localparam int CW = $clog2(MAX_TERMS+1);     // beat counter width

  // Saturation bounds, expressed one bit wider than the accumulator so the
  // raw sum can be compared before it is clamped.
  localparam logic signed [ACC_W:0] ACC_MAX_EXT = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN_EXT = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0]      ACC_ONE     = ACC_W'(1);
  localparam logic [ACC_W:0]        RND_HALF    = (ACC_W+1)'(1) << (FRAC-1);
  localparam logic [ACC_W:0]        OUT_MAX     = (ACC_W+1)'((2**(BIT-1))-1);
  localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]         CNT_LIMIT   = CW'(MAX_TERMS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q;
  logic [CW-1:0]     count_q;
  logic              valid_q;
  logic [BIT-1:0]    num_q;
  logic              sat_q;

  // Combinational next values
  logic [ACC_W-1:0]        mag_ext_d;
  logic [ACC_W-1:0]        term_d;
  logic signed [ACC_W:0]   sum_ext_d;
  logic [ACC_W-1:0]        acc_sum_d;
  logic                    add_ovf_d;
  logic [CW-1:0]           count_inc_d;
  logic [ACC_W-1:0]        acc_mag_d;
  logic [ACC_W:0]          rnd_full_d;
  logic [BIT-2:0]          rnd_mag_d;
  logic                    rnd_clip_d;
  logic [BIT-1:0]          rnd_num_d;
  logic                    rnd_sat_d;

  // ---------------------------------------------------------------------------
  // Term conversion and saturating add
  // ---------------------------------------------------------------------------
  always_comb begin
    mag_ext_d = {{(ACC_W-MW){1'b0}}, iProd[MW-1:0]};
    // Negating a zero magnitude yields zero, so -0 naturally becomes 0.
    term_d    = iProd[MW] ? (~mag_ext_d + ACC_ONE) : mag_ext_d;

    sum_ext_d = {acc_q[ACC_W-1], acc_q} + {term_d[ACC_W-1], term_d};
    acc_sum_d = sum_ext_d[ACC_W-1:0];
    add_ovf_d = 1'b0;
    // Clamp is symmetric: the most negative code is never stored, which keeps
    // |acc| representable in ACC_W bits for the rounding stage.
    if (sum_ext_d > ACC_MAX_EXT) begin
      acc_sum_d = ACC_MAX_EXT[ACC_W-1:0];
      add_ovf_d = 1'b1;
    end else if (sum_ext_d < ACC_MIN_EXT) begin
      acc_sum_d = ACC_MIN_EXT[ACC_W-1:0];
      add_ovf_d = 1'b1;
    end

    count_inc_d = count_q + CNT_ONE;
  end

  // ---------------------------------------------------------------------------
  // Round half away from zero on the magnitude, rescale, clip
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_mag_d  = acc_q[ACC_W-1] ? (~acc_q + ACC_ONE) : acc_q;
    rnd_full_d = ({1'b0, acc_mag_d} + RND_HALF) >> FRAC;
    rnd_clip_d = (rnd_full_d > OUT_MAX);
    rnd_mag_d  = rnd_clip_d ? OUT_MAX[BIT-2:0] : rnd_full_d[BIT-2:0];

`ifdef RELU_EN
    if (acc_q[ACC_W-1]) begin
      rnd_num_d = '0;
      rnd_sat_d = 1'b0;
    end else begin
      rnd_num_d = {1'b0, rnd_mag_d};
      rnd_sat_d = rnd_clip_d;
    end
`else
    // A result that rounds to zero is always emitted as +0.
    rnd_num_d = {acc_q[ACC_W-1] & (rnd_mag_d != '0), rnd_mag_d};
    rnd_sat_d = rnd_clip_d;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      num_q   <= '0;
      sat_q   <= 1'b0;
    end else if (iClear) begin
      // Abort wins over everything, including a beat offered the same cycle.
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iValid) begin
            acc_q   <= term_d;
            ovf_q   <= 1'b0;
            count_q <= CNT_ONE;
            state_q <= (iLast || (CNT_ONE == CNT_LIMIT)) ? S_ROUND : S_ACC;
          end
        end
        S_ACC: begin
          if (iValid) begin
            acc_q   <= acc_sum_d;
            ovf_q   <= ovf_q | add_ovf_d;
            count_q <= count_inc_d;
            // Length limit forces a close even without iLast.
            if (iLast || (count_inc_d == CNT_LIMIT)) begin
              state_q <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          num_q   <= rnd_num_d;
          sat_q   <= rnd_sat_d | ovf_q;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (iReady) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oReady = (state_q == S_IDLE) || (state_q == S_ACC);
  assign oValid = valid_q;
  assign oNum   = num_q;
  assign oSat   = sat_q;
  assign oCount = count_q;
  assign oState = state_q;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Directed vectors with hand-computed results for product_accumulator
// (BIT=16, FRAC=10). A second instance with MAX_TERMS=4 shares the stimulus
// and is checked for the forced-close behaviour.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iClear;
  logic        iValid;
  logic [30:0] iProd;
  logic        iLast;
  logic        iReady;

  logic        oReady,  oValid,  oSat;
  logic [15:0] oNum;
  logic [10:0] oCount;
  logic [1:0]  oState;

  logic        oReady4, oValid4, oSat4;
  logic [15:0] oNum4;
  logic [2:0]  oCount4;
  logic [1:0]  oState4;

  product_accumulator #(.BIT(16), .FRAC(10), .ACC_W(36), .MAX_TERMS(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .iClear(iClear), .iValid(iValid), .oReady(oReady),
    .iProd(iProd), .iLast(iLast), .oValid(oValid), .iReady(iReady),
    .oNum(oNum), .oSat(oSat), .oCount(oCount), .oState(oState)
  );

  product_accumulator #(.BIT(16), .FRAC(10), .ACC_W(36), .MAX_TERMS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .iClear(iClear), .iValid(iValid), .oReady(oReady4),
    .iProd(iProd), .iLast(iLast), .oValid(oValid4), .iReady(iReady),
    .oNum(oNum4), .oSat(oSat4), .oCount(oCount4), .oState(oState4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic sgn, input logic [29:0] mag, input logic last);
    iValid = 1'b1;
    iProd  = {sgn, mag};
    iLast  = last;
    @(posedge clk); #1;
    iValid = 1'b0;
    iLast  = 1'b0;
    iProd  = '0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp_num,
                            input logic exp_sat, input logic [10:0] exp_cnt);
    int k = 0;
    while (!oValid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_valid"}, oValid, 1'b1);
    check({tag, "_num"},   oNum,   exp_num);
    check({tag, "_sat"},   oSat,   exp_sat);
    check({tag, "_cnt"},   oCount, exp_cnt);
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    check({tag, "_drop"},  oValid, 1'b0);
  endtask

  localparam logic [29:0] M_1P0  = 30'd1048576;   // 1.0 in 2*FRAC
  localparam logic [29:0] M_3P0  = 30'd3145728;   // 1.5*2.0
  localparam logic [29:0] M_FULL = 30'h3FFF_FFFF;

`ifdef RELU_EN
  localparam logic [15:0] EXP_NEG2   = 16'h0000;
  localparam logic [15:0] EXP_NEGSAT = 16'h0000;
  localparam logic        EXP_NSAT   = 1'b0;
`else
  localparam logic [15:0] EXP_NEG2   = 16'h8800;
  localparam logic [15:0] EXP_NEGSAT = 16'hFFFF;
  localparam logic        EXP_NSAT   = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; iClear = 1'b0; iValid = 1'b0; iProd = '0; iLast = 1'b0; iReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", oValid, 1'b0);
    check("rst_num",   oNum,   16'h0000);
    check("rst_sat",   oSat,   1'b0);
    check("rst_cnt",   oCount, 11'd0);
    check("rst_ready", oReady, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat, latency
    send_beat(1'b0, M_3P0, 1'b1);
    check("t1_lat0",  oValid, 1'b0);
    check("t1_rdy0",  oReady, 1'b0);
    @(posedge clk); #1;
    check("t1_lat1",  oValid, 1'b1);
    get_result("t1", 16'h0C00, 1'b0, 11'd1);

    // Mixed signs
    send_beat(1'b0, M_3P0, 1'b0);
    send_beat(1'b1, M_1P0, 1'b1);
    get_result("t2a", 16'h0800, 1'b0, 11'd2);
    send_beat(1'b0, M_1P0, 1'b0);
    send_beat(1'b1, M_3P0, 1'b1);
    get_result("t2b", EXP_NEG2, 1'b0, 11'd2);

    // Reset mid-sum drops the partial sum
    send_beat(1'b0, M_1P0, 1'b0);
    send_beat(1'b0, M_1P0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rmid_cnt",   oCount, 11'd0);
    check("rmid_valid", oValid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rounding
    send_beat(1'b0, 30'd512, 1'b1);
    get_result("t3a", 16'h0001, 1'b0, 11'd1);
    send_beat(1'b0, 30'd511, 1'b1);
    get_result("t3b", 16'h0000, 1'b0, 11'd1);
    send_beat(1'b1, 30'd511, 1'b1);
    get_result("t3c", 16'h0000, 1'b0, 11'd1);

    // Saturation
    for (int i = 0; i < 4; i++) send_beat(1'b0, M_FULL, (i == 3));
    get_result("t4p", 16'h7FFF, 1'b1, 11'd4);
    for (int i = 0; i < 4; i++) send_beat(1'b1, M_FULL, (i == 3));
    get_result("t4n", EXP_NEGSAT, EXP_NSAT, 11'd4);

    // Hold with iReady low; offered beats ignored
    send_beat(1'b0, M_1P0, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1;
      iProd  = {1'b0, M_3P0};
      check("t5_hold_num", oNum,   16'h0400);
      check("t5_hold_rdy", oReady, 1'b0);
      @(posedge clk); #1;
    end
    iValid = 1'b0;
    iProd  = '0;
    get_result("t5hold", 16'h0400, 1'b0, 11'd1);

    // Clear after three beats; beat offered with iClear discarded
    for (int i = 0; i < 3; i++) send_beat(1'b0, M_3P0, 1'b0);
    check("t5_cnt3", oCount, 11'd3);
    iClear = 1'b1;
    iValid = 1'b1;
    iProd  = {1'b0, M_3P0};
    @(posedge clk); #1;
    iClear = 1'b0;
    iValid = 1'b0;
    iProd  = '0;
    check("t5_clr_cnt",   oCount, 11'd0);
    check("t5_clr_valid", oValid, 1'b0);
    check("t5_clr_rdy",   oReady, 1'b1);
    send_beat(1'b0, M_1P0, 1'b1);
    get_result("t5clr", 16'h0400, 1'b0, 11'd1);

    // Forced close at MAX_TERMS=4 on the second instance
    for (int i = 0; i < 4; i++) send_beat(1'b0, M_1P0, 1'b0);
    check("t6_rdy4",  oReady4, 1'b0);
    check("t6_rdy1",  oReady,  1'b1);
    @(posedge clk); #1;
    check("t6_valid4", oValid4, 1'b1);
    check("t6_num4",   oNum4,   16'h1000);
    check("t6_cnt4",   oCount4, 3'd4);
    check("t6_sat4",   oSat4,   1'b0);
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    check("t6_drop4", oValid4, 1'b0);
    send_beat(1'b0, M_1P0, 1'b1);
    @(posedge clk); #1;
    check("t6_new_num4", oNum4,   16'h0400);
    check("t6_new_cnt4", oCount4, 3'd1);
    get_result("t6dut1", 16'h1400, 1'b0, 11'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
